scan_misr: RTL and testbench



---
 rtl/scan_pkg.sv | 26 ++
 rtl/scan_misr_unload.sv | 41 ++++
 rtl/scan_misr.sv | 120 ++++++++++++
 tb/tb_scan_misr.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and the MISR compaction equation for the scan compaction block.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        HOLD    = 2'd2,
        UNLOAD  = 2'd3
    } misr_state_t;

    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'h0000;

    // Widths up to 64 are carried in 64-bit containers; bits above `width` are dropped.
    function automatic logic [63:0] misr_step(input logic [63:0] cur,
                                              input logic [63:0] d,
                                              input logic [63:0] poly,
                                              input int          width);
        logic [63:0] keep;
        logic [63:0] nxt;
        keep = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        nxt  = (cur << 1) ^ (cur[6'(width - 1)] ? poly : 64'd0) ^ d;
        return nxt & keep;
    endfunction

endpackage

// File: rtl/scan_misr_unload.sv
// Serializer: snapshots the signature into a shadow register and shifts it out MSB first.
module scan_misr_unload #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             abort,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    output logic             sig_out,
    output logic             sig_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shadow;
    logic [CW-1:0]    bit_cnt;

    // bit_cnt counts down the bits still to follow the one on sig_out.
    always_ff @(posedge clk) begin
        if (abort) begin
            shadow    <= '0;
            bit_cnt   <= '0;
            sig_valid <= 1'b0;
        end else if (start) begin
            shadow    <= load_val;
            bit_cnt   <= CW'(WIDTH - 1);
            sig_valid <= 1'b1;
        end else if (sig_valid) begin
            shadow  <= {shadow[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt - 1'b1;
            if (bit_cnt == '0) begin
                sig_valid <= 1'b0;
            end
        end
    end

    assign done    = sig_valid && (bit_cnt == '0);
    assign sig_out = sig_valid & shadow[WIDTH-1];

endmodule

// File: rtl/scan_misr.sv
// Multiple-input signature register compacting scan chain tails, with serial unload.
//   state   | meaning
//   IDLE    | cleared, waiting for shift or unload
//   COMPACT | compacting every tscan_enable cycle
//   HOLD    | signature frozen between shift phases
//   UNLOAD  | serializer shifting the signature out
module scan_misr
    import scan_pkg::*;
#(
    parameter int               NCHAIN = 4,
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(DEF_SEED)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tscan_enable,
    input  logic [NCHAIN-1:0] scan_in,
    input  logic [NCHAIN-1:0] scan_mask,
    input  logic              misr_clear,
    input  logic              misr_unload,
    output logic              sig_out,
    output logic              sig_valid,
    output logic [WIDTH-1:0]  signature,
    output logic [15:0]       shift_cnt,
    output logic              busy,
    output logic              unload_err
);

    if (NCHAIN > WIDTH || NCHAIN < 1 || WIDTH < 2 || WIDTH > 64) begin : g_bad_params
        $error("scan_misr: need 1 <= NCHAIN <= WIDTH and 2 <= WIDTH <= 64");
    end

    misr_state_t      state, state_next;
    logic [WIDTH-1:0] misr;
    logic [WIDTH-1:0] misr_next;
    logic [WIDTH-1:0] d_ext;
    logic             do_compact;
    logic             start_unload;
    logic             err_set;
    logic             unload_done;
    logic             abort;

    assign d_ext     = WIDTH'(scan_in & ~scan_mask);
    assign misr_next = WIDTH'(misr_step(64'(misr), 64'(d_ext), 64'(POLY), WIDTH));
    assign abort     = rst | misr_clear;

    always_comb begin
        state_next   = state;
        do_compact   = 1'b0;
        start_unload = 1'b0;
        err_set      = 1'b0;
        case (state)
            IDLE, HOLD: begin
                if (tscan_enable) begin
                    do_compact = 1'b1;
                    err_set    = misr_unload;
                    state_next = COMPACT;
                end else if (misr_unload) begin
                    start_unload = 1'b1;
                    state_next   = UNLOAD;
                end
            end
            COMPACT: begin
                if (tscan_enable) begin
                    do_compact = 1'b1;
                    err_set    = misr_unload;
                end else begin
                    state_next = HOLD;
                end
            end
            UNLOAD: begin
                err_set = tscan_enable;
                if (unload_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (abort) begin
            state      <= IDLE;
            misr       <= SEED;
            shift_cnt  <= 16'd0;
            unload_err <= 1'b0;
        end else begin
            state <= state_next;
            if (do_compact) begin
                misr <= misr_next;
                if (shift_cnt != 16'hFFFF) begin
                    shift_cnt <= shift_cnt + 16'd1;
                end
            end else if (state == UNLOAD && unload_done) begin
                misr      <= SEED;
                shift_cnt <= 16'd0;
            end
            if (err_set) begin
                unload_err <= 1'b1;
            end
        end
    end

    scan_misr_unload #(
        .WIDTH (WIDTH)
    ) u_unload (
        .clk       (clk),
        .abort     (abort),
        .start     (start_unload),
        .load_val  (misr),
        .sig_out   (sig_out),
        .sig_valid (sig_valid),
        .done      (unload_done)
    );

    assign signature = misr;
    assign busy      = (state == UNLOAD);

endmodule

// File: tb/tb_scan_misr.sv
// Randomized and directed bench for scan_misr against a behavioural signature model.
module tb_scan_misr;

    localparam logic [15:0] POLY = 16'h1021;
    localparam logic [15:0] SEED = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tscan_enable = 1'b0;
    logic [3:0]  scan_in = '0;
    logic [3:0]  scan_mask = '0;
    logic        misr_clear = 1'b0;
    logic        misr_unload = 1'b0;
    logic        sig_out;
    logic        sig_valid;
    logic [15:0] signature;
    logic [15:0] shift_cnt;
    logic        busy;
    logic        unload_err;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    logic [15:0] m_sig = SEED;
    int          m_cnt = 0;
    logic        m_err = 1'b0;
    logic        m_compacting = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_out = 1'b0;
    logic        q_bits[$];

    always #5 clk = ~clk;

    scan_misr dut (
        .clk          (clk),
        .rst          (rst),
        .tscan_enable (tscan_enable),
        .scan_in      (scan_in),
        .scan_mask    (scan_mask),
        .misr_clear   (misr_clear),
        .misr_unload  (misr_unload),
        .sig_out      (sig_out),
        .sig_valid    (sig_valid),
        .signature    (signature),
        .shift_cnt    (shift_cnt),
        .busy         (busy),
        .unload_err   (unload_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Signature as a polynomial over GF(2): multiply by x, reduce, add the new data word.
    function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [3:0] din, input logic [3:0] msk);
        logic [16:0] prod;
        prod = {s, 1'b0};
        if (prod[16]) prod = prod ^ {1'b1, POLY};
        return prod[15:0] ^ {12'd0, din & ~msk};
    endfunction

    task automatic model_update();
        if (rst || misr_clear) begin
            m_sig = SEED; m_cnt = 0; m_err = 1'b0; m_compacting = 1'b0;
            m_valid = 1'b0; m_out = 1'b0; q_bits.delete();
        end else if (m_valid) begin
            if (tscan_enable) m_err = 1'b1;
            if (q_bits.size() > 0) begin
                m_out = q_bits.pop_front();
            end else begin
                m_valid = 1'b0; m_out = 1'b0; m_sig = SEED; m_cnt = 0;
            end
        end else if (tscan_enable) begin
            if (misr_unload) m_err = 1'b1;
            m_sig = ref_step(m_sig, scan_in, scan_mask);
            if (m_cnt < 65535) m_cnt++;
            m_compacting = 1'b1;
        end else begin
            if (!m_compacting && misr_unload) begin
                for (int i = 15; i >= 0; i--) q_bits.push_back(m_sig[i]);
                m_out = q_bits.pop_front();
                m_valid = 1'b1;
            end
            m_compacting = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("signature", 32'(signature), 32'(m_sig));
        chk("shift_cnt", 32'(shift_cnt), 32'(m_cnt));
        chk("sig_valid", 32'(sig_valid), 32'(m_valid));
        chk("sig_out", 32'(sig_out), 32'(m_out));
        chk("busy", 32'(busy), 32'(m_valid));
        chk("unload_err", 32'(unload_err), 32'(m_err));
    endtask

    task automatic idle_inputs();
        rst = 1'b0; tscan_enable = 1'b0; scan_in = '0; scan_mask = '0;
        misr_clear = 1'b0; misr_unload = 1'b0;
    endtask

    logic [15:0] exp_bits;

    initial begin
        // reset
        rst = 1'b1;
        step(); step();
        chk("rst_signature", 32'(signature), 32'h0000);
        chk("rst_valid", 32'(sig_valid), 32'h0);
        idle_inputs();

        // first compaction steps
        tscan_enable = 1'b1; scan_in = 4'b0001;
        step();
        chk("first_compact", 32'(signature), 32'h0001);
        scan_in = 4'b0000;
        step();
        chk("second_compact", 32'(signature), 32'h0002);
        chk("second_cnt", 32'(shift_cnt), 32'd2);
        repeat (14) step();
        chk("preload_msb", 32'(signature), 32'h8000);
        step();
        chk("feedback", 32'(signature), 32'h1021);

        // masked chains behave as zeros
        misr_clear = 1'b1; tscan_enable = 1'b0; step(); misr_clear = 1'b0;
        tscan_enable = 1'b1; scan_in = 4'b0001; step();
        scan_in = 4'b1111; scan_mask = 4'b1111;
        repeat (16) step();
        chk("masked_feedback", 32'(signature), 32'h1021);
        chk("masked_cnt", 32'(shift_cnt), 32'd17);

        // hold for 10 cycles, then resume
        tscan_enable = 1'b0; scan_mask = '0;
        repeat (10) step();
        chk("hold_sig", 32'(signature), 32'h1021);
        chk("hold_cnt", 32'(shift_cnt), 32'd17);
        tscan_enable = 1'b1; scan_in = 4'b0000; step();
        chk("resume_sig", 32'(signature), 32'h2042);
        chk("resume_cnt", 32'(shift_cnt), 32'd18);

        // unload 16'h1021 serially
        misr_clear = 1'b1; tscan_enable = 1'b0; step(); misr_clear = 1'b0;
        tscan_enable = 1'b1; scan_in = 4'b0001; step();
        scan_in = 4'b0000; repeat (16) step();
        tscan_enable = 1'b0; step();
        chk("pre_unload_sig", 32'(signature), 32'h1021);
        misr_unload = 1'b1; step(); misr_unload = 1'b0;
        exp_bits = 16'h1021;
        for (int i = 15; i >= 0; i--) begin
            chk("unload_valid", 32'(sig_valid), 32'h1);
            chk("unload_bit", 32'(sig_out), 32'(exp_bits[i]));
            chk("unload_sig_stable", 32'(signature), 32'h1021);
            if (i > 0) step();
        end
        step();
        chk("post_unload_valid", 32'(sig_valid), 32'h0);
        chk("post_unload_sig", 32'(signature), 32'(SEED));
        chk("post_unload_cnt", 32'(shift_cnt), 32'd0);
        chk("post_unload_busy", 32'(busy), 32'h0);

        // illegal unload request is sticky until clear, reset also clears it
        tscan_enable = 1'b1; misr_unload = 1'b1; scan_in = 4'b0101; step();
        misr_unload = 1'b0;
        chk("err_set", 32'(unload_err), 32'h1);
        chk("err_no_unload", 32'(busy), 32'h0);
        tscan_enable = 1'b0; repeat (5) step();
        chk("err_sticky", 32'(unload_err), 32'h1);
        misr_clear = 1'b1; step(); misr_clear = 1'b0;
        chk("err_clear", 32'(unload_err), 32'h0);
        tscan_enable = 1'b1; misr_unload = 1'b1; step();
        misr_unload = 1'b0; tscan_enable = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        chk("err_rst", 32'(unload_err), 32'h0);

        // abort an unload at bit 5
        tscan_enable = 1'b1; scan_in = 4'b1011; repeat (7) step();
        tscan_enable = 1'b0; step();
        misr_unload = 1'b1; step(); misr_unload = 1'b0;
        repeat (5) step();
        misr_clear = 1'b1; step(); misr_clear = 1'b0;
        chk("abort_valid", 32'(sig_valid), 32'h0);
        chk("abort_sig", 32'(signature), 32'h0000);
        step();
        chk("abort_idle_busy", 32'(busy), 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) < 12) tscan_enable = ~tscan_enable;
            scan_in     = 4'($urandom);
            scan_mask   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            misr_unload = ($urandom_range(0, 14) == 0);
            misr_clear  = ($urandom_range(0, 299) == 0);
            rst         = ($urandom_range(0, 999) == 0);
            step();
        end
        idle_inputs();
        step();

        // shift counter saturation
        misr_clear = 1'b1; step(); misr_clear = 1'b0;
        tscan_enable = 1'b1;
        for (int n = 0; n < 70000; n++) begin
            scan_in = 4'($urandom);
            step();
        end
        chk("cnt_saturate", 32'(shift_cnt), 32'h0000FFFF);
        tscan_enable = 1'b0; step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
